// File: rtl/mm_rd_arb_pkg.sv
// Shared types and the round-robin pick function for the memory-mapped read/write arbiters.
package mm_rd_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_t;

  localparam int CNT_W  = 3;
  localparam int MAX_CH = 8;
  localparam int PTR_W  = 3;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } rr_pick_t;

  // First set bit of eligible at or after pointer, wrapping modulo num.
  // Scanning offsets downward lets the smallest offset overwrite the result last.
  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] eligible,
                                       input logic [PTR_W-1:0]  pointer,
                                       input int                num);
    rr_pick_t res;
    int       cand;
    res = '0;
    for (int ofs = MAX_CH - 1; ofs >= 0; ofs--) begin
      if (ofs < num) begin
        cand = (int'(pointer) + ofs) % num;
        if (eligible[cand]) begin
          res.found = 1'b1;
          res.idx   = cand[PTR_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mm_rd_arbiter_core.sv
// Round-robin priority pointer and masked search; pointer advances past the issued index.
import mm_rd_arb_pkg::*;

module rr_arbiter_core #(
  parameter int NUM = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM-1:0]   i_req,
  input  logic             i_issue,
  input  logic [PTR_W-1:0] i_issue_idx,
  output logic             o_found,
  output logic [PTR_W-1:0] o_winner
);

  logic [PTR_W-1:0]  r_pointer;
  logic [MAX_CH-1:0] w_req_ext;
  rr_pick_t          w_pick;

  always_comb begin
    w_req_ext          = '0;
    w_req_ext[NUM-1:0] = i_req;
  end

  assign w_pick   = rr_pick(w_req_ext, r_pointer, NUM);
  assign o_found  = w_pick.found;
  assign o_winner = w_pick.idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pointer <= '0;
    end else if (i_issue) begin
      r_pointer <= (i_issue_idx == PTR_W'(NUM - 1)) ? '0 : i_issue_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/mm_rd_arbiter.sv
// Shares one AXI4 read port between NUM channels: round-robin AR grants with per-channel
// outstanding limits, and R beats routed back by rid. rid_err is registered (pulses one cycle after the beat).
import mm_rd_arb_pkg::*;

module mm_rd_arbiter #(
  parameter int NUM       = 4,
  parameter int ASIZE     = 29,
  parameter int LSIZE     = 9,
  parameter int IDSIZE    = 4,
  parameter int ID_BASE   = 0,
  parameter int MAX_OUT   = 2,
  parameter int AXI_DSIZE = 256
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM-1:0]       s_arvalid,
  input  logic [NUM*ASIZE-1:0] s_araddr,
  input  logic [NUM*LSIZE-1:0] s_arlen,
  output logic [NUM-1:0]       s_arready,
  output logic [IDSIZE-1:0]    m_arid,
  output logic [ASIZE-1:0]     m_araddr,
  output logic [LSIZE-1:0]     m_arlen,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  input  logic [IDSIZE-1:0]    m_rid,
  input  logic [AXI_DSIZE-1:0] m_rdata,
  input  logic                 m_rlast,
  input  logic                 m_rvalid,
  output logic                 m_rready,
  output logic [NUM-1:0]       s_rvalid,
  output logic [NUM-1:0]       s_rlast,
  output logic [AXI_DSIZE-1:0] s_rdata,
  input  logic [NUM-1:0]       s_rready,
  output logic [NUM*3-1:0]     outstanding,
  output logic                 rid_err
);

  arb_state_t       r_state, w_state_next;
  logic [PTR_W-1:0] r_winner;
  logic [IDSIZE-1:0] r_arid;
  logic [ASIZE-1:0] r_araddr;
  logic [LSIZE-1:0] r_arlen;
  logic             r_arvalid;
  logic             r_rid_err;
  logic [CNT_W-1:0] r_cnt [NUM];

  logic [NUM-1:0]    w_eligible;
  logic              w_found;
  logic [PTR_W-1:0]  w_pick;
  logic              w_grant;
  logic              w_ar_hs;
  logic [ASIZE-1:0]  w_araddr_sel;
  logic [LSIZE-1:0]  w_arlen_sel;
  logic [IDSIZE-1:0] w_idx;
  logic              w_in_range;
  logic [NUM-1:0]    w_sel;
  logic [NUM-1:0]    w_inc;
  logic [NUM-1:0]    w_dec;
  logic [NUM-1:0]    w_underflow;

  rr_arbiter_core #(.NUM(NUM)) u_rr_core (
    .clk         (clock),
    .rst         (rst),
    .i_req       (w_eligible),
    .i_issue     (w_ar_hs),
    .i_issue_idx (r_winner),
    .o_found     (w_found),
    .o_winner    (w_pick)
  );

  assign w_grant  = (r_state == ST_IDLE) && w_found;
  assign w_ar_hs  = (r_state == ST_ISSUE) && r_arvalid && m_arready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_found) w_state_next = ST_ISSUE;
      ST_ISSUE: if (w_ar_hs) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_araddr_sel = '0;
    w_arlen_sel  = '0;
    for (int k = 0; k < NUM; k++) begin
      if (w_pick == PTR_W'(k)) begin
        w_araddr_sel = s_araddr[k*ASIZE +: ASIZE];
        w_arlen_sel  = s_arlen[k*LSIZE +: LSIZE];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // AR fields are captured only at grant, so they stay stable through ISSUE.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_arvalid <= 1'b0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_winner  <= '0;
    end else if (w_grant) begin
      r_arvalid <= 1'b1;
      r_arid    <= IDSIZE'(ID_BASE) + IDSIZE'(w_pick);
      r_araddr  <= w_araddr_sel;
      r_arlen   <= w_arlen_sel;
      r_winner  <= w_pick;
    end else if (w_ar_hs) begin
      r_arvalid <= 1'b0;
    end
  end

  assign m_arvalid = r_arvalid;
  assign m_arid    = r_arid;
  assign m_araddr  = r_araddr;
  assign m_arlen   = r_arlen;

  assign w_idx      = m_rid - IDSIZE'(ID_BASE);
  assign w_in_range = int'(w_idx) < NUM;
  assign m_rready   = w_in_range ? |(s_rready & w_sel) : 1'b1;
  assign s_rdata    = m_rdata;

  generate
    for (genvar gi = 0; gi < NUM; gi++) begin : g_ch
      assign w_eligible[gi] = enable && s_arvalid[gi] && (r_cnt[gi] < CNT_W'(MAX_OUT));
      assign s_arready[gi]  = w_grant && (w_pick == PTR_W'(gi));
      assign w_sel[gi]      = w_in_range && (w_idx == IDSIZE'(gi));
      assign s_rvalid[gi]   = m_rvalid && w_sel[gi];
      assign s_rlast[gi]    = m_rlast && w_sel[gi];
      assign w_inc[gi]      = w_ar_hs && (r_winner == PTR_W'(gi));
      assign w_dec[gi]      = m_rvalid && m_rready && m_rlast && w_sel[gi];
      assign w_underflow[gi] = w_dec[gi] && !w_inc[gi] && (r_cnt[gi] == '0);
      assign outstanding[gi*3 +: 3] = r_cnt[gi];

      always_ff @(posedge clock) begin
        if (rst) begin
          r_cnt[gi] <= '0;
        end else if (w_inc[gi] && !w_dec[gi]) begin
          r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
        end else if (w_dec[gi] && !w_inc[gi] && (r_cnt[gi] != '0)) begin
          r_cnt[gi] <= r_cnt[gi] - CNT_W'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (rst) begin
      r_rid_err <= 1'b0;
    end else begin
      r_rid_err <= (m_rvalid && !w_in_range) || (|w_underflow);
    end
  end

  assign rid_err = r_rid_err;

endmodule

// File: tb/tb_mm_rd_arbiter.sv
// Directed bench for mm_rd_arbiter: grants, fairness, limits, backpressure, R routing, reset.
module tb_mm_rd_arbiter;

  localparam int NUM = 4, ASIZE = 29, LSIZE = 9, IDSIZE = 4;
  localparam int ID_BASE = 0, MAX_OUT = 2, DSIZE = 256;

  logic                 clock = 1'b0;
  logic                 rst, enable;
  logic [NUM-1:0]       s_arvalid, s_arready;
  logic [NUM*ASIZE-1:0] s_araddr;
  logic [NUM*LSIZE-1:0] s_arlen;
  logic [IDSIZE-1:0]    m_arid, m_rid;
  logic [ASIZE-1:0]     m_araddr;
  logic [LSIZE-1:0]     m_arlen;
  logic                 m_arvalid, m_arready;
  logic [DSIZE-1:0]     m_rdata, s_rdata;
  logic                 m_rlast, m_rvalid, m_rready;
  logic [NUM-1:0]       s_rvalid, s_rlast, s_rready;
  logic [NUM*3-1:0]     outstanding;
  logic                 rid_err;

  int checks = 0;
  int failures = 0;
  int grants;

  always #5 clock = ~clock;

  mm_rd_arbiter #(
    .NUM(NUM), .ASIZE(ASIZE), .LSIZE(LSIZE), .IDSIZE(IDSIZE),
    .ID_BASE(ID_BASE), .MAX_OUT(MAX_OUT), .AXI_DSIZE(DSIZE)
  ) dut (
    .clock(clock), .rst(rst), .enable(enable),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arready(s_arready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rdata(s_rdata), .s_rready(s_rready),
    .outstanding(outstanding), .rid_err(rid_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [2:0] cnt_of(input int k);
    return outstanding[k*3 +: 3];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    s_arvalid = '0; m_arready = 1'b0;
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rid = '0; s_rready = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    enable = 1'b1; s_araddr = '0; s_arlen = '0; m_rdata = '0;
    do_reset();
    rst = 1'b1;
    step();
    check("rst_arvalid", m_arvalid, 0);
    check("rst_arid", m_arid, 0);
    check("rst_araddr", m_araddr, 0);
    check("rst_arlen", m_arlen, 0);
    check("rst_arready", s_arready, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_rid_err", rid_err, 0);
    rst = 1'b0;

    // enable low blocks new grants
    enable = 1'b0; s_arvalid = 4'b1111;
    settle();
    check("en_low_arready", s_arready, 0);
    step();
    check("en_low_arvalid", m_arvalid, 0);
    s_arvalid = '0; enable = 1'b1;

    // single request on channel 1
    s_araddr[1*ASIZE +: ASIZE] = 29'h1000;
    s_arlen[1*LSIZE +: LSIZE]  = 9'd199;
    s_arvalid = 4'b0010;
    settle();
    check("single_arready", s_arready, 4'b0010);
    step();
    s_arvalid = '0;
    settle();
    check("single_arvalid", m_arvalid, 1);
    check("single_arid", m_arid, 1);
    check("single_araddr", m_araddr, 29'h1000);
    check("single_arlen", m_arlen, 199);
    check("single_issue_no_arready", s_arready, 0);
    m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    check("single_hs_arvalid", m_arvalid, 0);
    check("single_cnt1_inc", cnt_of(1), 1);
    m_rid = 4'd1; m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 4'b0010;
    m_rdata = {4{64'hDEAD_BEEF_0123_4567}};
    settle();
    check("single_s_rvalid", s_rvalid, 4'b0010);
    check("single_s_rlast", s_rlast, 4'b0010);
    check("single_m_rready", m_rready, 1);
    check("single_rdata", s_rdata[63:0], 64'hDEAD_BEEF_0123_4567);
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    check("single_cnt1_dec", cnt_of(1), 0);
    check("single_no_err", rid_err, 0);

    // fairness: all channels request continuously
    do_reset();
    for (int k = 0; k < NUM; k++) s_araddr[k*ASIZE +: ASIZE] = ASIZE'(32'h100 * k);
    s_arvalid = 4'b1111; m_arready = 1'b1;
    for (int g = 0; g < 8; g++) begin
      settle();
      check($sformatf("fair_arready_g%0d", g), s_arready, 64'(1) << (g % 4));
      check($sformatf("fair_idle_g%0d", g), m_arvalid, 0);
      step();
      check($sformatf("fair_arvalid_g%0d", g), m_arvalid, 1);
      check($sformatf("fair_arid_g%0d", g), m_arid, g % 4);
      check($sformatf("fair_araddr_g%0d", g), m_araddr, 32'h100 * (g % 4));
      step();
    end
    settle();
    check("fair_all_at_limit", s_arready, 0);
    check("fair_outstanding", outstanding, 12'b010_010_010_010);
    s_arvalid = '0; m_arready = 1'b0;

    // outstanding limit on channel 0
    do_reset();
    s_arvalid = 4'b0001; m_arready = 1'b1; grants = 0;
    for (int c = 0; c < 8; c++) begin
      settle();
      if (s_arready[0]) grants++;
      step();
    end
    check("limit_first_grants", grants, 2);
    check("limit_cnt0_full", cnt_of(0), 2);
    m_rid = 4'd0; m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 4'b0001;
    settle();
    check("limit_blocked_during_rlast", s_arready, 0);
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    grants = 0;
    for (int c = 0; c < 8; c++) begin
      settle();
      if (s_arready[0]) grants++;
      step();
    end
    check("limit_one_more_grant", grants, 1);
    check("limit_cnt0_refull", cnt_of(0), 2);
    s_arvalid = '0; m_arready = 1'b0;

    // backpressure during ISSUE
    do_reset();
    s_araddr[2*ASIZE +: ASIZE] = 29'h0ABC;
    s_arlen[2*LSIZE +: LSIZE]  = 9'd5;
    s_arvalid = 4'b0100;
    settle();
    check("bp_grant", s_arready, 4'b0100);
    step();
    s_arvalid = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) s_araddr[2*ASIZE +: ASIZE] = 29'h0FFF;
      settle();
      check($sformatf("bp_arvalid_c%0d", c), m_arvalid, 1);
      check($sformatf("bp_arid_c%0d", c), m_arid, 2);
      check($sformatf("bp_araddr_c%0d", c), m_araddr, 29'h0ABC);
      check($sformatf("bp_arlen_c%0d", c), m_arlen, 5);
      check($sformatf("bp_no_arready_c%0d", c), s_arready, 0);
      step();
    end
    m_arready = 1'b1; s_arvalid = '0;
    step();
    m_arready = 1'b0;
    check("bp_accepted", m_arvalid, 0);
    check("bp_cnt2", cnt_of(2), 1);

    // R routing with a stalled channel, then an out-of-range rid
    m_rid = 4'd2; m_rvalid = 1'b1; m_rlast = 1'b0; s_rready = 4'b1011;
    settle();
    check("route_rready_stall", m_rready, 0);
    check("route_s_rvalid", s_rvalid, 4'b0100);
    check("route_s_rlast", s_rlast, 0);
    step();
    check("route_no_err", rid_err, 0);
    m_rid = 4'd9; m_rlast = 1'b1;
    settle();
    check("badrid_rready", m_rready, 1);
    check("badrid_s_rvalid", s_rvalid, 0);
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    check("badrid_err_pulse", rid_err, 1);
    check("badrid_cnt2_kept", cnt_of(2), 1);
    step();
    check("badrid_err_clear", rid_err, 0);

    // rlast for a channel with nothing outstanding
    m_rid = 4'd3; m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 4'b1000;
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    check("underflow_err", rid_err, 1);
    check("underflow_cnt3", cnt_of(3), 0);

    // simultaneous increment and decrement on channel 3
    do_reset();
    s_araddr[3*ASIZE +: ASIZE] = 29'h3000;
    s_arlen[3*LSIZE +: LSIZE]  = 9'd7;
    s_arvalid = 4'b1000;
    settle();
    step();
    s_arvalid = '0; m_arready = 1'b1;
    step();
    m_arready = 1'b0;
    check("simul_cnt3_pre", cnt_of(3), 1);
    s_arvalid = 4'b1000;
    settle();
    step();
    s_arvalid = '0; m_arready = 1'b1;
    m_rid = 4'd3; m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 4'b1000;
    settle();
    check("simul_rready", m_rready, 1);
    step();
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    check("simul_cnt3_same", cnt_of(3), 1);
    check("simul_arvalid", m_arvalid, 0);
    check("simul_no_err", rid_err, 0);

    // reset during ISSUE
    s_arvalid = 4'b1000;
    settle();
    step();
    s_arvalid = '0;
    check("rstiss_arvalid_pre", m_arvalid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstiss_arvalid", m_arvalid, 0);
    check("rstiss_outstanding", outstanding, 0);
    settle();
    check("rstiss_arready", s_arready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mm_rd_arbiter.md
Name: mm_rd_arbiter

Overview:
- Round-robin scheduler that shares one AXI4 read port between NUM video read channels.
- Each channel is an mm_rev-style AR/R master. The block sits between the channels' read state cores and the memory interconnect.
- It grants the AR channel one request at a time, tags each request with a per-channel ID, and bounds outstanding bursts per channel.
- It routes R beats back to the owning channel by rid.

Parameters:
- NUM, 4: number of requesting channels (2..8).
- ASIZE, 29: address width.
- LSIZE, 9: burst-length field width.
- IDSIZE, 4: AXI ID width.
- ID_BASE, 0: ID issued to channel 0. Channel k is issued ID_BASE+k; ID_BASE+NUM-1 must fit in IDSIZE bits.
- MAX_OUT, 2: maximum outstanding bursts per channel (1..7).
- AXI_DSIZE, 256: read data width.

Ports:
- clock  in  1  single clock, equal to axi_aclk.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  when low, no new grants are issued; in-flight bursts still complete.
- s_arvalid  in  NUM  per-channel read request.
- s_araddr  in  NUM*ASIZE  channel k address at bits [k*ASIZE +: ASIZE].
- s_arlen  in  NUM*LSIZE  channel k burst length (beats-1) at bits [k*LSIZE +: LSIZE].
- s_arready  out  NUM  one-hot request-accepted strobe.
- m_arid  out  IDSIZE  issued ID.
- m_araddr  out  ASIZE  issued address.
- m_arlen  out  LSIZE  issued burst length.
- m_arvalid  out  1  AR valid.
- m_arready  in  1  AR ready.
- m_rid  in  IDSIZE  R ID.
- m_rdata  in  AXI_DSIZE  R data.
- m_rlast  in  1  R last.
- m_rvalid  in  1  R valid.
- m_rready  out  1  R ready.
- s_rvalid  out  NUM  routed R valid.
- s_rlast  out  NUM  routed R last.
- s_rdata  out  AXI_DSIZE  m_rdata broadcast to all channels.
- s_rready  in  NUM  per-channel R ready.
- outstanding  out  NUM*3  per-channel outstanding burst count.
- rid_err  out  1  one-cycle pulse when an R beat's rid is out of range.

Behaviour:
- Reset values: m_arvalid=0, m_arid=0, m_araddr=0, m_arlen=0, s_arready=0, rid_err=0, all outstanding counters=0, priority pointer=0, state=IDLE.
- Reset asserted mid-burst discards all tracking; the owner of the block resets the downstream fabric at the same time.
- eligible[k] = enable & s_arvalid[k] & (cnt[k] < MAX_OUT).
- Two-state FSM, IDLE and ISSUE:
  - IDLE: if any eligible channel exists, winner = first eligible index at or after the pointer, searching with modulo-NUM wrap.
  - IDLE, grant cycle: s_arready[winner]=1 (combinational, this cycle only). On the clock edge, m_araddr/m_arlen take the winner's fields, m_arid <= ID_BASE+winner, m_arvalid <= 1, go to ISSUE.
  - IDLE, no eligible channel: stay in IDLE; s_arready=0.
  - ISSUE: m_ar* held stable while m_arvalid=1. On m_arvalid & m_arready: m_arvalid <= 0, cnt[winner]++, pointer <= (winner+1) mod NUM, go to IDLE.
- Latency: s_arvalid to m_arvalid is 1 cycle. Peak rate is one AR every 2 cycles.
- Requesters hold s_arvalid until s_arready. Dropping s_arvalid before s_arready cancels the request without side effects.
- R routing (combinational):
  - idx = m_rid - ID_BASE.
  - If idx < NUM: s_rvalid[idx] = m_rvalid, s_rlast[idx] = m_rlast, m_rready = s_rready[idx]. All other s_rvalid/s_rlast are 0.
  - If idx is out of range: m_rready=1 (beat dropped) and rid_err pulses on each such accepted beat.
- Counters:
  - cnt[k]-- on m_rvalid & m_rready & m_rlast & idx==k.
  - Increment and decrement on the same cycle for the same k leave cnt unchanged.
  - A decrement at 0 saturates at 0 and pulses rid_err.
- enable low during ISSUE does not cancel the held AR.
- Widths: ID arithmetic is done in IDSIZE bits; each counter is 3 bits.

Decomposition:
- Package mm_rd_arb_pkg holds:
  - the state encoding (IDLE, ISSUE);
  - the CNT_W=3 constant;
  - the function rr_pick(eligible, pointer), returning the winner index and a found flag.
- Sub-module rr_arbiter_core: pointer register, masked priority search, and pointer update on an issue strobe. It is reused by the write-side arbiter.

Test Plan:
- Single request: ch1 requests addr 0x1000, len 199, ID_BASE=0. Required: s_arready[1] in cycle 0; m_arvalid in cycle 1 with m_arid=1, m_araddr=0x1000, m_arlen=199; cnt[1]=1 after handshake; cnt[1]=0 after an R beat with rid=1 and rlast.
- Fairness: all 4 channels hold s_arvalid continuously and m_arready=1. Required grant order 0,1,2,3,0,…; m_arvalid is high every other cycle.
- Outstanding limit: MAX_OUT=2, ch0 keeps requesting, no R returns. Required: after 2 grants s_arready[0] stays 0; after 1 rlast with rid=0, exactly one further grant.
- Backpressure: m_arready=0 for 10 cycles during ISSUE. Required: m_ar* stable for all 10 cycles; no new s_arready; accepted on the first cycle m_arready=1.
- R routing and errors: rid=2 with s_rready[2]=0. Required: m_rready=0 and only s_rvalid[2] high. Then rid=9 with NUM=4. Required: m_rready=1, rid_err pulses, all s_rvalid low.
- Simultaneous events and reset: grant handshake for ch3 on the same cycle as an rlast for ch3. Required: cnt[3] unchanged. Then rst held 1 cycle during ISSUE. Required: m_arvalid=0 and all counters 0 on the next cycle.
